// File: rtl/saw_voice_scheduler.sv
// Time-shares one registered saw LUT across NUM_CH phase-accumulator voices,
// scanning every voice once per sample_tick and emitting volume-scaled samples.
module saw_voice_scheduler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned PHASE_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_tick,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [15:0]               cfg_inc,
    input  logic [7:0]                cfg_vol,
    input  logic                      cfg_phase_clr,
    output logic [8:0]                lut_addr,
    input  logic [15:0]               lut_data,
    output logic [15:0]               smp_data,
    output logic [$clog2(NUM_CH)-1:0] smp_ch,
    output logic                      smp_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned LUT_W = 9;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic                drain_cnt;

    logic [PHASE_W-1:0]  phase [NUM_CH];
    logic [PHASE_W-1:0]  inc   [NUM_CH];
    logic [7:0]          vol   [NUM_CH];

    logic                v1, v2;
    logic [CH_W-1:0]     ch1, ch2;
    logic [7:0]          vol1, vol2;

    logic                issue_c;
    logic signed [24:0]  prod_c;

    assign issue_c = (state == SCAN);
    assign prod_c  = 25'($signed(lut_data)) * 25'($signed({1'b0, vol2}));

    // Scan sequencer: IDLE -> SCAN (one voice per cycle) -> DRAIN (2 cycles) -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            lut_addr  <= '0;
        end else begin
            overrun <= sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= SCAN;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    lut_addr <= phase[ch][PHASE_W-1 -: LUT_W];
                    ch       <= ch + 1'b1;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    drain_cnt <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Voice registers; a phase clear on the voice being issued beats its accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                vol[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    inc[i] <= PHASE_W'(cfg_inc);
                    vol[i] <= cfg_vol;
                end
                if (cfg_we && cfg_phase_clr && (cfg_ch == CH_W'(i))) begin
                    phase[i] <= '0;
                end else if (issue_c && (ch == CH_W'(i))) begin
                    phase[i] <= phase[i] + inc[i];
                end
            end
        end
    end

    // Two-stage carry of voice index and volume to meet the LUT read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            ch1       <= '0;
            ch2       <= '0;
            vol1      <= '0;
            vol2      <= '0;
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_ch    <= '0;
        end else begin
            v1 <= issue_c;
            if (issue_c) begin
                ch1  <= ch;
                vol1 <= vol[ch];
            end
            v2        <= v1;
            ch2       <= ch1;
            vol2      <= vol1;
            smp_valid <= v2;
            if (v2) begin
                smp_data <= 16'(prod_c >>> 8);
                smp_ch   <= ch2;
            end
        end
    end

endmodule

// File: tb/tb_saw_voice_scheduler.sv
// Bench for saw_voice_scheduler: registered saw LUT model, voice model and
// expected-sample queue checked against every smp_valid beat.
module tb_saw_voice_scheduler;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned PHASE_W = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_inc = '0;
    logic [7:0]  cfg_vol = '0;
    logic        cfg_phase_clr = 1'b0;
    logic [8:0]  lut_addr;
    logic [15:0] lut_data = '0;
    logic [15:0] smp_data;
    logic [1:0]  smp_ch;
    logic        smp_valid;
    logic        busy;
    logic        overrun;

    saw_voice_scheduler #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_vol(cfg_vol),
        .cfg_phase_clr(cfg_phase_clr), .lut_addr(lut_addr), .lut_data(lut_data),
        .smp_data(smp_data), .smp_ch(smp_ch), .smp_valid(smp_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) lut_data <= 16'(int'(lut_addr) * 128 - 32768);

    typedef struct {
        logic signed [15:0] data;
        logic [1:0]         ch;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_valid = 0;

    logic [23:0] m_phase [NUM_CH];
    logic [15:0] m_inc   [NUM_CH];
    logic [7:0]  m_vol   [NUM_CH];
    logic [8:0]  exp_addr  [NUM_CH];
    logic [8:0]  last_addr [NUM_CH];
    logic signed [15:0] first_smp;

    function automatic logic signed [15:0] scaled(input logic [8:0] addr, input logic [7:0] v);
        int d, p;
        d = int'(addr) * 128 - 32768;
        p = d * int'(v);
        return 16'(p >>> 8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_phase[i] = '0;
            m_inc[i]   = '0;
            m_vol[i]   = '0;
        end
    endtask

    // Predicts one scan: addresses from pre-update phase, samples queued in voice order
    task automatic push_scan(input int clr_ch);
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_addr[c] = m_phase[c][23:15];
            e.data = scaled(exp_addr[c], m_vol[c]);
            e.ch   = 2'(c);
            exp_q.push_back(e);
            m_phase[c] = m_phase[c] + 24'(m_inc[c]);
        end
        if (clr_ch >= 0) m_phase[clr_ch] = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n && smp_valid) begin
            exp_t e;
            n_valid++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid ch=%0d data=%0d want=no_output", smp_ch, $signed(smp_data));
            end else begin
                e = exp_q.pop_front();
                if (smp_data !== e.data || smp_ch !== e.ch) begin
                    bad++;
                    $display("FAIL sample got ch=%0d data=%0d want ch=%0d data=%0d",
                             smp_ch, $signed(smp_data), e.ch, e.data);
                end
            end
        end
    end

    task automatic cfg(input int ch, input int inc, input int v, input bit clr);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_inc = 16'(inc); cfg_vol = 8'(v); cfg_phase_clr = clr;
        @(negedge clk);
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
        m_inc[ch] = 16'(inc);
        m_vol[ch] = 8'(v);
        if (clr) m_phase[ch] = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_timeout got=%0b want=0", busy);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // One full scan; optionally pulses cfg_phase_clr in voice clr_ch's issue cycle
    task automatic do_tick(input int clr_ch);
        push_scan(clr_ch);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == clr_ch) begin
                cfg_we = 1'b1; cfg_ch = 2'(c); cfg_inc = m_inc[c]; cfg_vol = m_vol[c];
                cfg_phase_clr = 1'b1;
            end
            @(negedge clk);
            cfg_we = 1'b0; cfg_phase_clr = 1'b0;
            last_addr[c] = lut_addr;
            total++;
            if (lut_addr !== exp_addr[c]) begin
                bad++;
                $display("FAIL lut_addr v%0d got=%0d want=%0d", c, lut_addr, exp_addr[c]);
            end
            if (c == 1) begin
                total++;
                if (smp_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL early_valid got=%0b want=0", smp_valid);
                end
            end
            if (c == 2) begin
                first_smp = smp_data;
                total++;
                if (smp_valid !== 1'b1 || smp_ch !== 2'd0) begin
                    bad++;
                    $display("FAIL first_valid got v=%0b ch=%0d want v=1 ch=0", smp_valid, smp_ch);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (lut_addr !== 9'd0 || smp_data !== 16'd0 || smp_ch !== 2'd0 ||
            smp_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got addr=%0d data=%0d ch=%0d v=%0b busy=%0b ov=%0b want all 0",
                     lut_addr, smp_data, smp_ch, smp_valid, busy, overrun);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (n_valid !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet got valids=%0d busy=%0b want 0 0", n_valid, busy);
        end
    endtask

    task automatic test_ramp();
        cfg(0, 16'h8000, 255, 1'b0);
        for (int t = 0; t < 3; t++) begin
            do_tick(-1);
            total++;
            if (last_addr[0] !== 9'(t)) begin
                bad++;
                $display("FAIL ramp_addr got=%0d want=%0d", last_addr[0], t);
            end
            if (t == 0) begin
                total++;
                if (first_smp !== -16'sd32640) begin
                    bad++;
                    $display("FAIL ramp_first got=%0d want=-32640", first_smp);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int ov = 0;
        int n0;
        n0 = n_valid;
        push_scan(-1);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0; ov += int'(overrun);
        @(negedge clk); sample_tick = 1'b1; ov += int'(overrun);
        @(negedge clk); sample_tick = 1'b0; ov += int'(overrun);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ov += int'(overrun);
        end
        total++;
        if (ov !== 1) begin
            bad++;
            $display("FAIL overrun_pulses got=%0d want=1", ov);
        end
        total++;
        if (n_valid - n0 !== NUM_CH) begin
            bad++;
            $display("FAIL overrun_valids got=%0d want=%0d", n_valid - n0, NUM_CH);
        end
    endtask

    task automatic test_wrap();
        bit wrapped = 1'b0;
        logic [8:0] prev;
        cfg(1, 16'hFFFF, 200, 1'b0);
        prev = '0;
        for (int t = 0; t < 300; t++) begin
            do_tick(-1);
            if (last_addr[1] < prev) wrapped = 1'b1;
            prev = last_addr[1];
        end
        do_tick(-1);
        total++;
        if (last_addr[1] !== 9'd87) begin
            bad++;
            $display("FAIL wrap_phase got=%0d want=87", last_addr[1]);
        end
        total++;
        if (wrapped !== 1'b1) begin
            bad++;
            $display("FAIL wrap_seen got=%0b want=1", wrapped);
        end
    endtask

    task automatic test_volume();
        cfg(0, 0, 0, 1'b0);
        do_tick(-1);
        total++;
        if (first_smp !== 16'sd0) begin
            bad++;
            $display("FAIL vol_zero got=%0d want=0", first_smp);
        end
        cfg(0, 16'hFFFF, 0, 1'b1);
        for (int t = 0; t < 256; t++) do_tick(-1);
        cfg(0, 0, 128, 1'b0);
        do_tick(-1);
        total++;
        if (last_addr[0] !== 9'd511 || first_smp !== 16'sd16320) begin
            bad++;
            $display("FAIL vol_half got addr=%0d data=%0d want addr=511 data=16320",
                     last_addr[0], first_smp);
        end
    endtask

    task automatic test_phase_clr();
        cfg(2, 16'h8000, 100, 1'b0);
        do_tick(-1);
        do_tick(2);
        total++;
        if (last_addr[2] !== 9'd1) begin
            bad++;
            $display("FAIL clr_old_addr got=%0d want=1", last_addr[2]);
        end
        do_tick(-1);
        total++;
        if (last_addr[2] !== 9'd0) begin
            bad++;
            $display("FAIL clr_new_addr got=%0d want=0", last_addr[2]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (smp_valid !== 1'b0 || busy !== 1'b0 || lut_addr !== 9'd0) begin
            bad++;
            $display("FAIL mid_reset got v=%0b busy=%0b addr=%0d want 0 0 0", smp_valid, busy, lut_addr);
        end
        exp_q.delete();
        model_reset();
        n0 = n_valid;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (n_valid !== n0) begin
            bad++;
            $display("FAIL post_reset_valid got=%0d want=0", n_valid - n0);
        end
        cfg(0, 16'h8000, 255, 1'b0);
        do_tick(-1);
        total++;
        if (last_addr[0] !== 9'd0 || first_smp !== -16'sd32640) begin
            bad++;
            $display("FAIL restart got addr=%0d data=%0d want addr=0 data=-32640", last_addr[0], first_smp);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_overrun();
        test_wrap();
        test_volume();
        test_phase_clr();
        test_reset_mid_scan();
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
